// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S TX/RX memory controllers: controller state
// encoding and the layout of a sample inside a 32-bit FIFO word.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } mem_state_t;

    localparam int SAMPLE_LR_BIT   = 31;
    localparam int SAMPLE_DATA_MSB = 23;

    function automatic logic [31:0] pack_sample(input logic lr, input logic [23:0] data);
        logic [31:0] word;
        word                    = '0;
        word[SAMPLE_LR_BIT]     = lr;
        word[SAMPLE_DATA_MSB:0] = data;
        return word;
    endfunction

endpackage

// File: rtl/i2s_rx_mem_controller.sv
// Receive-side memory controller: accepts I2S reader samples over a four-phase
// handshake and writes packed words into whichever ping-pong buffer it holds.
module i2s_rx_mem_controller
    import i2s_pkg::*;
#(
    parameter int IDLE_TIMEOUT  = 1024,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int OVF_WIDTH     = 16
) (
    input  logic                 rst,
    input  logic                 i2s_clock,
    input  logic                 enable,
    input  logic                 audio_data_valid,
    input  logic [23:0]          audio_data,
    input  logic                 audio_lr_bit,
    output logic                 audio_data_ack,
    input  logic [1:0]           wfifo_ready,
    input  logic [23:0]          wfifo_size,
    output logic [1:0]           wfifo_activate,
    output logic                 wfifo_strobe,
    output logic [31:0]          wfifo_data,
    output logic                 overflow,
    output logic [OVF_WIDTH-1:0] overflow_count
);

    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_LIMIT = TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [OVF_WIDTH-1:0]     OVF_ONE    = OVF_WIDTH'(1);
    localparam logic [OVF_WIDTH-1:0]     OVF_MAX    = '1;

    mem_state_t               state, state_next;
    logic [23:0]              word_count, word_count_next, word_count_inc;
    logic [TIMEOUT_WIDTH-1:0] idle_count, idle_count_next;
    logic [1:0]               activate_next;
    logic                     strobe_next;
    logic [31:0]              data_next;
    logic                     ack_next;
    logic                     overflow_next;
    logic [OVF_WIDTH-1:0]     ovf_count_next;
    logic                     consumed;
    logic                     sample_pending;

    assign sample_pending = audio_data_valid && !audio_data_ack;
    assign word_count_inc = word_count + 24'd1;

    always_ff @(posedge i2s_clock or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            word_count     <= '0;
            idle_count     <= '0;
            wfifo_activate <= '0;
            wfifo_strobe   <= 1'b0;
            wfifo_data     <= '0;
            audio_data_ack <= 1'b0;
            overflow       <= 1'b0;
            overflow_count <= '0;
        end else begin
            state          <= state_next;
            word_count     <= word_count_next;
            idle_count     <= idle_count_next;
            wfifo_activate <= activate_next;
            wfifo_strobe   <= strobe_next;
            wfifo_data     <= data_next;
            audio_data_ack <= ack_next;
            overflow       <= overflow_next;
            overflow_count <= ovf_count_next;
        end
    end

    always_comb begin
        state_next      = state;
        word_count_next = word_count;
        idle_count_next = idle_count;
        activate_next   = wfifo_activate;
        strobe_next     = 1'b0;
        data_next       = wfifo_data;
        overflow_next   = overflow;
        ovf_count_next  = overflow_count;
        consumed        = 1'b0;

        case (state)
            IDLE: begin
                if (enable && wfifo_ready != 2'b00) begin
                    activate_next   = wfifo_ready[0] ? 2'b01 : 2'b10;
                    word_count_next = '0;
                    idle_count_next = '0;
                    state_next      = ACTIVE;
                end else if (enable && sample_pending) begin
                    consumed      = 1'b1;
                    overflow_next = 1'b1;
                    if (overflow_count != OVF_MAX) begin
                        ovf_count_next = overflow_count + OVF_ONE;
                    end
                end
            end

            ACTIVE: begin
                // The buffer stays claimed through the final write so its strobe
                // never appears without an activate; other exits drop it at once.
                if (!enable || word_count >= wfifo_size) begin
                    activate_next = '0;
                    state_next    = RELEASE;
                end else if (sample_pending) begin
                    consumed        = 1'b1;
                    strobe_next     = 1'b1;
                    data_next       = pack_sample(audio_lr_bit, audio_data);
                    word_count_next = word_count_inc;
                    idle_count_next = '0;
                    if (word_count_inc == wfifo_size) begin
                        state_next = RELEASE;
                    end
                end else if (word_count != '0) begin
                    if (idle_count == IDLE_LIMIT) begin
                        activate_next = '0;
                        state_next    = RELEASE;
                    end else begin
                        idle_count_next = idle_count + IDLE_ONE;
                    end
                end
            end

            RELEASE: begin
                activate_next = '0;
                state_next    = IDLE;
            end

            default: begin
                activate_next = '0;
                state_next    = IDLE;
            end
        endcase

        ack_next = enable && (audio_data_ack ? audio_data_valid : consumed);
    end

endmodule

// File: tb/tb_i2s_rx_mem_controller.sv
// Self-checking bench for i2s_rx_mem_controller: a scoreboard queue of packed
// words is filled as samples are driven and drained by a strobe monitor.
module tb_i2s_rx_mem_controller;

    localparam int IDLE_TIMEOUT  = 8;
    localparam int TIMEOUT_WIDTH = 16;
    localparam int OVF_WIDTH     = 4;

    logic                 rst;
    logic                 i2s_clock;
    logic                 enable;
    logic                 audio_data_valid;
    logic [23:0]          audio_data;
    logic                 audio_lr_bit;
    logic                 audio_data_ack;
    logic [1:0]           wfifo_ready;
    logic [23:0]          wfifo_size;
    logic [1:0]           wfifo_activate;
    logic                 wfifo_strobe;
    logic [31:0]          wfifo_data;
    logic                 overflow;
    logic [OVF_WIDTH-1:0] overflow_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [23:0] data;
        logic        lr;
        logic [31:0] word;
    } vec_t;

    vec_t full_vecs[4];

    i2s_rx_mem_controller #(
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH),
        .OVF_WIDTH    (OVF_WIDTH)
    ) dut (
        .rst             (rst),
        .i2s_clock       (i2s_clock),
        .enable          (enable),
        .audio_data_valid(audio_data_valid),
        .audio_data      (audio_data),
        .audio_lr_bit    (audio_lr_bit),
        .audio_data_ack  (audio_data_ack),
        .wfifo_ready     (wfifo_ready),
        .wfifo_size      (wfifo_size),
        .wfifo_activate  (wfifo_activate),
        .wfifo_strobe    (wfifo_strobe),
        .wfifo_data      (wfifo_data),
        .overflow        (overflow),
        .overflow_count  (overflow_count)
    );

    initial begin
        i2s_clock = 1'b0;
        forever #5 i2s_clock = ~i2s_clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one sample through the full four-phase handshake from a negedge.
    task automatic apply_stimulus(input logic [23:0] data, input logic lr,
                                  input bit expect_write, input logic [31:0] word);
        int lat;
        if (expect_write) exp_q.push_back(word);
        audio_data       = data;
        audio_lr_bit     = lr;
        audio_data_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge i2s_clock);
            lat++;
        end while (!audio_data_ack && lat < 20);
        check_output("ack_latency", 32'(lat), 32'd1);
        audio_data_valid = 1'b0;
        @(negedge i2s_clock);
        check_output("ack_release", 32'(audio_data_ack), 32'd0);
    endtask

    task automatic settle();
        enable           = 1'b0;
        wfifo_ready      = 2'b00;
        audio_data_valid = 1'b0;
        repeat (4) @(negedge i2s_clock);
    endtask

    always @(negedge i2s_clock) begin
        if (!rst && wfifo_strobe) begin
            check_output("strobe_activate", 32'(wfifo_activate != 2'b00), 32'd1);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_strobe: got data 0x%08h, expected no strobe", wfifo_data);
            end else begin
                check_output("strobe_data", wfifo_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [23:0] d;

        full_vecs[0] = '{24'h123456, 1'b0, 32'h00123456};
        full_vecs[1] = '{24'hABCDEF, 1'b1, 32'h80ABCDEF};
        full_vecs[2] = '{24'h000001, 1'b0, 32'h00000001};
        full_vecs[3] = '{24'hFFFFFF, 1'b1, 32'h80FFFFFF};

        rst              = 1'b1;
        enable           = 1'b0;
        audio_data_valid = 1'b0;
        audio_data       = '0;
        audio_lr_bit     = 1'b0;
        wfifo_ready      = 2'b00;
        wfifo_size       = '0;
        repeat (2) @(negedge i2s_clock);
        check_output("reset_activate", 32'(wfifo_activate), 32'd0);
        check_output("reset_strobe", 32'(wfifo_strobe), 32'd0);
        check_output("reset_data", wfifo_data, 32'd0);
        check_output("reset_ack", 32'(audio_data_ack), 32'd0);
        check_output("reset_overflow", 32'(overflow), 32'd0);
        check_output("reset_ovf_count", 32'(overflow_count), 32'd0);
        rst = 1'b0;
        @(negedge i2s_clock);

        $display("[TB] full block");
        wfifo_ready = 2'b01;
        wfifo_size  = 24'd4;
        enable      = 1'b1;
        @(negedge i2s_clock);
        check_output("full_claim", 32'(wfifo_activate), 32'h1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(full_vecs[i].data, full_vecs[i].lr, 1'b1, full_vecs[i].word);
        end
        check_output("full_release_gap", 32'(wfifo_activate), 32'h0);
        @(negedge i2s_clock);
        check_output("full_reclaim", 32'(wfifo_activate), 32'h1);
        check_output("full_sb_drained", 32'(exp_q.size()), 32'd0);
        settle();

        $display("[TB] ping-pong");
        wfifo_ready = 2'b11;
        wfifo_size  = 24'd2;
        enable      = 1'b1;
        @(negedge i2s_clock);
        check_output("pp_first_claim", 32'(wfifo_activate), 32'h1);
        for (int i = 0; i < 2; i++) begin
            d = 24'h5A0000 | 24'(i);
            apply_stimulus(d, i[0], 1'b1, {i[0], 7'h0, d});
        end
        check_output("pp_release", 32'(wfifo_activate), 32'h0);
        wfifo_ready = 2'b10;
        @(negedge i2s_clock);
        check_output("pp_second_claim", 32'(wfifo_activate), 32'h2);
        for (int i = 2; i < 4; i++) begin
            d = 24'hA50000 | 24'(i);
            apply_stimulus(d, i[0], 1'b1, {i[0], 7'h0, d});
        end
        check_output("pp_sb_drained", 32'(exp_q.size()), 32'd0);
        settle();

        $display("[TB] overflow");
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(24'h0F0F00 | 24'(i), 1'b0, 1'b0, 32'h0);
        end
        check_output("ovf_flag", 32'(overflow), 32'd1);
        check_output("ovf_count_3", 32'(overflow_count), 32'd3);
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(24'h111111, 1'b1, 1'b0, 32'h0);
        end
        check_output("ovf_count_max", 32'(overflow_count), 32'hF);
        apply_stimulus(24'h222222, 1'b0, 1'b0, 32'h0);
        check_output("ovf_count_saturate", 32'(overflow_count), 32'hF);
        enable           = 1'b0;
        audio_data_valid = 1'b1;
        repeat (3) @(negedge i2s_clock);
        check_output("disabled_no_ack", 32'(audio_data_ack), 32'd0);
        check_output("disabled_count_held", 32'(overflow_count), 32'hF);
        check_output("disabled_flag_held", 32'(overflow), 32'd1);
        settle();

        $display("[TB] timeout flush");
        wfifo_ready = 2'b01;
        wfifo_size  = 24'd16;
        enable      = 1'b1;
        @(negedge i2s_clock);
        for (int i = 0; i < 3; i++) begin
            d = 24'h300000 | 24'(i);
            apply_stimulus(d, 1'b1, 1'b1, {1'b1, 7'h0, d});
        end
        repeat (6) @(negedge i2s_clock);
        check_output("timeout_still_held", 32'(wfifo_activate), 32'h1);
        @(negedge i2s_clock);
        check_output("timeout_flush", 32'(wfifo_activate), 32'h0);
        check_output("timeout_sb_drained", 32'(exp_q.size()), 32'd0);
        settle();

        $display("[TB] enable drop");
        wfifo_ready = 2'b01;
        wfifo_size  = 24'd8;
        enable      = 1'b1;
        @(negedge i2s_clock);
        for (int i = 0; i < 2; i++) begin
            d = 24'h440000 | 24'(i);
            apply_stimulus(d, 1'b0, 1'b1, {1'b0, 7'h0, d});
        end
        enable           = 1'b0;
        audio_data       = 24'h445566;
        audio_data_valid = 1'b1;
        @(negedge i2s_clock);
        check_output("endrop_activate", 32'(wfifo_activate), 32'h0);
        check_output("endrop_ack", 32'(audio_data_ack), 32'd0);
        repeat (2) @(negedge i2s_clock);
        check_output("endrop_ack_held", 32'(audio_data_ack), 32'd0);
        check_output("endrop_sb_drained", 32'(exp_q.size()), 32'd0);
        settle();

        $display("[TB] async reset");
        wfifo_ready = 2'b01;
        wfifo_size  = 24'd8;
        enable      = 1'b1;
        @(negedge i2s_clock);
        apply_stimulus(24'h777777, 1'b1, 1'b1, 32'h80777777);
        #2 rst = 1'b1;
        #1;
        check_output("rst_activate", 32'(wfifo_activate), 32'h0);
        check_output("rst_data", wfifo_data, 32'h0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        check_output("rst_ovf_count", 32'(overflow_count), 32'd0);
        @(negedge i2s_clock);
        rst = 1'b0;
        @(negedge i2s_clock);
        check_output("rst_reclaim", 32'(wfifo_activate), 32'h1);
        settle();

        $display("[TB] zero-size buffer");
        wfifo_ready      = 2'b01;
        wfifo_size       = 24'd0;
        enable           = 1'b1;
        audio_data       = 24'h999999;
        audio_data_valid = 1'b1;
        @(negedge i2s_clock);
        check_output("zero_claim", 32'(wfifo_activate), 32'h1);
        @(negedge i2s_clock);
        check_output("zero_release", 32'(wfifo_activate), 32'h0);
        repeat (4) @(negedge i2s_clock);
        check_output("zero_no_ack", 32'(audio_data_ack), 32'd0);
        check_output("zero_no_drop", 32'(overflow_count), 32'd0);
        settle();

        check_output("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_rx_mem_controller.md
Name: i2s_rx_mem_controller

Overview:
Receive-side counterpart of the I2S transmit memory controller. Takes 24-bit samples from the I2S reader over a four-phase valid/ack handshake. Packs each sample into a 32-bit word and fills the write side of a ping-pong FIFO, entirely in the i2s_clock domain; the FIFO carries the data across to the Wishbone clock. Handles buffer selection, block-complete release, idle-timeout flush of partial blocks, and overflow accounting when no buffer is free.

Parameters:
IDLE_TIMEOUT, 1024, i2s_clock cycles with no accepted sample before a partially filled buffer is released
TIMEOUT_WIDTH, 16, width of the idle counter (must hold IDLE_TIMEOUT)
OVF_WIDTH, 16, width of the overflow drop counter

Ports:
rst  input  1  asynchronous, active-high reset
i2s_clock  input  1  block clock; all logic is on its rising edge
enable  input  1  block enable; low stops activity and releases any held buffer
audio_data_valid  input  1  I2S reader presents a sample; held until ack is seen
audio_data  input  24  sample, left-justified
audio_lr_bit  input  1  channel of the sample (1 = right)
audio_data_ack  output  1  sample consumed (written or dropped)
wfifo_ready  input  2  ping-pong buffers available for writing
wfifo_size  input  24  capacity in words of the activated buffer
wfifo_activate  output  2  one-hot claim of a buffer; 0 = none
wfifo_strobe  output  1  one-cycle write pulse
wfifo_data  output  32  {audio_lr_bit, 7'h0, audio_data}
overflow  output  1  sticky: a sample was dropped since reset
overflow_count  output  OVF_WIDTH  dropped samples; saturates at all-ones

Behaviour:
- Reset (async, rst=1): all outputs 0. State IDLE. Internal word count and idle counter 0.
- Handshake (four-phase):
  - A sample is pending when audio_data_valid=1 and audio_data_ack=0.
  - The controller asserts ack exactly once per sample: registered, one cycle after it writes or drops the sample.
  - ack stays high until valid is seen low, then clears on the next edge.
  - A new sample is not accepted while ack=1.
- IDLE:
  - If enable=1 and wfifo_ready!=0: set wfifo_activate to bit 0 if ready[0], else bit 1 (bit 0 wins ties). Clear the count. Go to ACTIVE next cycle.
  - If enable=1, wfifo_ready==0 and a sample is pending: drop it. Assert ack, set overflow, increment overflow_count (saturating).
  - A pending sample while a buffer is ready is not dropped; it waits for ACTIVE.
- ACTIVE:
  - On a pending sample with count<wfifo_size: next cycle wfifo_strobe=1, wfifo_data=packed word, ack=1, count+1, idle counter cleared.
  - Latency is 1 cycle from valid seen to strobe.
  - When the write makes count==wfifo_size, go to RELEASE on that same edge.
  - wfifo_size==0 on entry: go to RELEASE immediately, with no write.
  - Idle counter increments each cycle with no accepted sample, only while count>0. At IDLE_TIMEOUT-1, go to RELEASE (partial-block flush).
  - With count==0 a buffer may be held indefinitely.
- RELEASE: wfifo_activate=0 for one cycle, then IDLE. A sample pending here waits; it is not dropped.
- enable deasserted:
  - From ACTIVE: next edge goes to RELEASE (partial data is kept); any in-flight strobe completes.
  - While enable=0: no new strobes, no drops, ack forced to 0. overflow and overflow_count are held.
- wfifo_strobe is never asserted while wfifo_activate==0. At most one strobe per sample.
- Reset mid-block: outputs go to 0 immediately. The FIFO is reset by its owner with the same rst.

Decomposition:
- Shared i2s package holds:
  - state encodings IDLE=2'd0, ACTIVE=2'd1, RELEASE=2'd2;
  - sample-word field positions (LR bit 31, data [23:0]), used by both the TX and RX memory controllers.
- No sub-module; counters and the FSM stay in one file. The ping-pong FIFO is instantiated by the parent.

Test Plan:
- Full block:
  - Stimulus: ready=2'b01, size=4; send 4 samples 0x123456/L, 0xABCDEF/R, 0x000001/L, 0xFFFFFF/R.
  - Response: activate=01; strobes carry 0x00123456, 0x80ABCDEF, 0x00000001, 0x80FFFFFF; then activate=00 for one cycle, back to IDLE.
- Ping-pong:
  - Stimulus: ready=2'b11, size=2; send 4 samples.
  - Response: first block on activate=01. Second block uses activate=10 once the testbench clears ready[0].
- Overflow:
  - Stimulus: ready=00; send 3 samples.
  - Response: each acked within 2 cycles, no strobe, overflow=1, overflow_count=3. A 0xFFFF preload plus one more drop stays at 0xFFFF.
- Timeout flush:
  - Stimulus: IDLE_TIMEOUT=8, size=16; send 3 samples, then stop.
  - Response: 8 cycles after the last strobe, activate drops to 00.
- Enable drop:
  - Stimulus: deassert enable after 2 of 4 writes.
  - Response: activate=00 next cycle, no further strobes, ack=0.
- Async reset:
  - Stimulus: assert rst mid-block, between clock edges.
  - Response: all outputs 0 before the next edge; state IDLE after release.
